// File: rtl/match_ctrl.sv
// Pong match referee: turns ball miss flags into one-cycle point pulses and
// sequences serve, play, post-point pause and game-over.
module match_ctrl #(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned PAUSE_FRAMES = 90
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       btn_start,
  output logic [1:0] score,
  output logic       score_clr,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned PTS_W = 7;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTS_W-1:0]   pts0_q, pts0_d;
  logic [PTS_W-1:0]   pts1_q, pts1_d;
  logic               start_q, start_d;
  logic [1:0]         score_q, score_d;
  logic               score_clr_q, score_clr_d;
  logic               ball_reset_q, ball_reset_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               start_rise;

  assign start_rise = btn_start & ~start_q;

  // Next-state, point bookkeeping and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pts0_d      = pts0_q;
    pts1_d      = pts1_q;
    start_d     = btn_start;
    score_d     = 2'b00;
    score_clr_d = 1'b0;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          score_clr_d = 1'b1;
          pts0_d      = '0;
          pts1_d      = '0;
          serve_dir_d = 1'b0;
          winner_d    = 1'b0;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (cnt_q == CNT_W'(SERVE_FRAMES)) begin
          state_d = ST_PLAY;
        end else if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAY: begin
        // Left miss wins ties so only one point is ever awarded per rally
        if (miss_left) begin
          score_d     = 2'b10;
          pts1_d      = pts1_q + PTS_W'(1);
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end else if (miss_right) begin
          score_d     = 2'b01;
          pts0_d      = pts0_q + PTS_W'(1);
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (cnt_q == CNT_W'(PAUSE_FRAMES)) begin
          if (pts0_q == PTS_W'(WIN_SCORE)) begin
            winner_d = 1'b0;
            state_d  = ST_OVER;
          end else if (pts1_q == PTS_W'(WIN_SCORE)) begin
            winner_d = 1'b1;
            state_d  = ST_OVER;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame counter restarts on every state entry; an entry-edge tick is dropped
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    ball_reset_d = (state_d != ST_PLAY);
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pts0_q       <= '0;
      pts1_q       <= '0;
      start_q      <= 1'b0;
      score_q      <= 2'b00;
      score_clr_q  <= 1'b0;
      ball_reset_q <= 1'b1;
      serve_dir_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pts0_q       <= pts0_d;
      pts1_q       <= pts1_d;
      start_q      <= start_d;
      score_q      <= score_d;
      score_clr_q  <= score_clr_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign score      = score_q;
  assign score_clr  = score_clr_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: pulse scoreboard with cycle-exact expectations plus
// directed level checks; a second instance with WIN_SCORE=1 shares the stimulus.
module tb_match_ctrl;

  localparam int unsigned SERVE_F = 60;
  localparam int unsigned PAUSE_F = 90;

  logic       clk50M = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       btn_start = 1'b0;
  logic [1:0] score, score_w1;
  logic       score_clr, ball_reset, serve_dir, game_over, winner;
  logic       score_clr_w1, ball_reset_w1, serve_dir_w1, game_over_w1, winner_w1;

  match_ctrl #(.WIN_SCORE(11), .SERVE_FRAMES(SERVE_F), .PAUSE_FRAMES(PAUSE_F)) u_dut (
    .clk50M(clk50M), .reset(reset), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .btn_start(btn_start),
    .score(score), .score_clr(score_clr), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  match_ctrl #(.WIN_SCORE(1), .SERVE_FRAMES(SERVE_F), .PAUSE_FRAMES(PAUSE_F)) u_w1 (
    .clk50M(clk50M), .reset(reset), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .btn_start(btn_start),
    .score(score_w1), .score_clr(score_clr_w1), .ball_reset(ball_reset_w1),
    .serve_dir(serve_dir_w1), .game_over(game_over_w1), .winner(winner_w1)
  );

  always #10 clk50M = ~clk50M;

  typedef struct {
    logic [1:0] sc;
    logic       clr;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every score/score_clr pulse must match the head of the queue
  always @(negedge clk50M) begin
    ev_t ev;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      ev = exp_q.pop_front();
      chk("pulse_missing_due_cycle", cyc, ev.cyc);
    end
    if (score != 2'b00 || score_clr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_sc_clr", int'({score, score_clr}), 0);
      end else begin
        ev = exp_q.pop_front();
        chk("pulse_cycle", cyc, ev.cyc);
        chk("pulse_value_sc_clr", int'({score, score_clr}), int'({ev.sc, ev.clr}));
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk50M);
      frame_tick = 1'b0;
      nclk(2);
    end
  endtask

  // Returns one half-cycle after the edge that samples the n-th tick
  task automatic frames_to_edge(input int n);
    frames(n - 1);
    frame_tick = 1'b1;
    @(negedge clk50M);
    frame_tick = 1'b0;
  endtask

  task automatic serve_to_play();
    frames_to_edge(SERVE_F);
    chk("ball_reset_at_last_serve_tick", int'(ball_reset), 1);
    @(negedge clk50M);
    chk("ball_reset_in_play", int'(ball_reset), 0);
  endtask

  task automatic press_start(input int hold, input logic with_tick);
    btn_start  = 1'b1;
    frame_tick = with_tick;
    exp_q.push_back('{sc: 2'b00, clr: 1'b1, cyc: cyc + 1});
    @(negedge clk50M);
    frame_tick = 1'b0;
    nclk(hold - 1);
    btn_start = 1'b0;
    @(negedge clk50M);
  endtask

  task automatic point(input logic l, input logic r, input int hold);
    miss_left  = l;
    miss_right = r;
    exp_q.push_back('{sc: (l ? 2'b10 : 2'b01), clr: 1'b0, cyc: cyc + 1});
    nclk(hold);
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  initial begin
    nclk(3);
    chk("rst_ball_reset", int'(ball_reset), 1);
    chk("rst_serve_dir", int'(serve_dir), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_w1_game_over", int'(game_over_w1), 0);
    reset = 1'b0;
    @(negedge clk50M);

    // Start with a coincident frame tick that must not be counted; held button
    press_start(5, 1'b1);
    chk("game_over_after_start", int'(game_over), 0);
    serve_to_play();
    chk("serve_dir_first_serve", int'(serve_dir), 0);

    // Lingering right miss: one point to player 0
    point(1'b0, 1'b1, 10);
    chk("serve_dir_after_p0_point", int'(serve_dir), 1);
    chk("ball_reset_in_point", int'(ball_reset), 1);
    frames_to_edge(PAUSE_F);
    chk("w1_game_over_before_exit", int'(game_over_w1), 0);
    @(negedge clk50M);
    chk("w1_game_over_after_pause", int'(game_over_w1), 1);
    chk("w1_winner", int'(winner_w1), 0);
    chk("game_over_not_won", int'(game_over), 0);
    serve_to_play();
    chk("serve_dir_held_in_play", int'(serve_dir), 1);

    // Both misses together: left priority
    point(1'b1, 1'b1, 3);
    chk("serve_dir_after_both_miss", int'(serve_dir), 0);
    frames(PAUSE_F);
    serve_to_play();

    // Start toggles in PLAY are ignored
    repeat (3) begin
      btn_start = 1'b1;
      @(negedge clk50M);
      btn_start = 1'b0;
      @(negedge clk50M);
    end
    chk("ball_reset_after_start_toggle", int'(ball_reset), 0);

    // Player 1 reaches 11 points
    for (int i = 2; i <= 11; i++) begin
      point(1'b1, 1'b0, 1);
      if (i < 11) begin
        frames(PAUSE_F);
        serve_to_play();
      end
    end
    frames_to_edge(PAUSE_F);
    chk("game_over_before_exit", int'(game_over), 0);
    @(negedge clk50M);
    chk("game_over_after_win", int'(game_over), 1);
    chk("winner_p1", int'(winner), 1);
    chk("ball_reset_in_over", int'(ball_reset), 1);

    // Misses in OVER give no score pulses
    miss_left = 1'b1;
    nclk(2);
    miss_left  = 1'b0;
    miss_right = 1'b1;
    nclk(2);
    miss_right = 1'b0;
    nclk(3);
    chk("game_over_held", int'(game_over), 1);
    chk("winner_held", int'(winner), 1);

    press_start(1, 1'b0);
    chk("game_over_cleared", int'(game_over), 0);
    chk("winner_cleared", int'(winner), 0);
    serve_to_play();

    // Reset mid-pause
    point(1'b0, 1'b1, 2);
    frames(40);
    reset = 1'b1;
    @(negedge clk50M);
    reset = 1'b0;
    chk("mid_rst_ball_reset", int'(ball_reset), 1);
    chk("mid_rst_serve_dir", int'(serve_dir), 0);
    chk("mid_rst_game_over", int'(game_over), 0);
    frames(120);
    chk("idle_holds_after_rst", int'(ball_reset), 1);
    press_start(1, 1'b0);
    serve_to_play();
    chk("serve_dir_fresh_game", int'(serve_dir), 0);

    nclk(5);
    while (exp_q.size() > 0) begin
      chk("pulse_never_seen_due_cycle", -1, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
